// File: rtl/mac_slot_scheduler.sv
// Time-division scheduler that shares one 4-cycle half-precision MAC among four dot-product channels.
// Each channel owns one issue slot per rotation, so its partial sum comes back just as its next slot arrives.
module mac_slot_scheduler #(
  parameter int NCH     = 4,
  parameter int MAC_LAT = 4,
  parameter int LEN_W   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH-1:0]       start,
  input  logic [NCH*LEN_W-1:0] len,
  output logic [NCH-1:0]       busy,
  input  logic [NCH-1:0]       op_valid,
  output logic [NCH-1:0]       op_ready,
  input  logic [NCH*16-1:0]    op_a,
  input  logic [NCH*16-1:0]    op_b,
  output logic [NCH-1:0]       res_valid,
  input  logic [NCH-1:0]       res_ready,
  output logic [NCH*32-1:0]    res_data,
  output logic                 mac_en,
  output logic [15:0]          mac_a,
  output logic [15:0]          mac_b,
  output logic [31:0]          mac_c,
  input  logic [31:0]          mac_q,
  output logic [2*NCH-1:0]     dbg_state
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             r_state     [NCH];
  state_t             w_state_nxt [NCH];
  logic [LEN_W-1:0]   r_rem       [NCH];
  logic [31:0]        r_acc       [NCH];
  logic [NCH-1:0]     r_first;
  logic [CW-1:0]      r_slot;
  logic [MAC_LAT-1:0] r_tag_v;
  logic [CW-1:0]      r_tag_ch    [MAC_LAT];

  logic [NCH-1:0]     w_own;
  logic [NCH-1:0]     w_hs;
  logic [NCH-1:0]     w_wb;
  logic [LEN_W-1:0]   w_len       [NCH];
  logic               w_issue;

  // Operand handshake: a pair transfers on a rising edge where op_valid[i] && op_ready[i];
  // op_ready[i] never depends on op_valid[i]. Results transfer on res_valid[i] && res_ready[i].
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_own[i] = (r_slot == CW'(i));
      w_hs[i]  = (r_state[i] == ST_RUN) && w_own[i] && op_valid[i];
      w_wb[i]  = r_tag_v[MAC_LAT-1] && (r_tag_ch[MAC_LAT-1] == CW'(i));
      w_len[i] = len[i*LEN_W +: LEN_W];
    end
  end

  assign w_issue = |w_hs;
  assign mac_en  = 1'b1;

  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_hs[i]) begin
        mac_a = op_a[i*16 +: 16];
        mac_b = op_b[i*16 +: 16];
        // The previous partial sum may be on mac_q this very cycle, before it lands in r_acc.
        if (r_first[i])  mac_c = '0;
        else if (w_wb[i]) mac_c = mac_q;
        else              mac_c = r_acc[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_IDLE: if (start[i]) w_state_nxt[i] = (w_len[i] != '0) ? ST_RUN : ST_DONE;
        ST_RUN:  if (w_hs[i] && (r_rem[i] == LEN_W'(1))) w_state_nxt[i] = ST_WAIT;
        ST_WAIT: if (w_wb[i]) w_state_nxt[i] = ST_DONE;
        ST_DONE: if (res_ready[i]) w_state_nxt[i] = ST_IDLE;
        default: w_state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      busy[i]                = (r_state[i] != ST_IDLE);
      op_ready[i]            = (r_state[i] == ST_RUN) && w_own[i];
      res_valid[i]           = (r_state[i] == ST_DONE);
      res_data[i*32 +: 32]   = (r_state[i] == ST_DONE) ? r_acc[i] : 32'h0;
      dbg_state[2*i +: 2]    = r_state[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_slot  <= '0;
      r_tag_v <= '0;
      r_first <= '0;
      for (int k = 0; k < MAC_LAT; k++) r_tag_ch[k] <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= ST_IDLE;
        r_rem[i]   <= '0;
        r_acc[i]   <= '0;
      end
    end else begin
      r_slot      <= (r_slot == CW'(NCH-1)) ? '0 : r_slot + 1'b1;
      r_tag_v     <= {r_tag_v[MAC_LAT-2:0], w_issue};
      r_tag_ch[0] <= r_slot;
      for (int k = 1; k < MAC_LAT; k++) r_tag_ch[k] <= r_tag_ch[k-1];
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (w_wb[i]) r_acc[i] <= mac_q;
        if (w_hs[i]) begin
          r_rem[i]   <= r_rem[i] - LEN_W'(1);
          r_first[i] <= 1'b0;
        end
        if ((r_state[i] == ST_IDLE) && start[i]) begin
          r_rem[i]   <= w_len[i];
          r_first[i] <= 1'b1;
          if (w_len[i] == '0) r_acc[i] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_slot_scheduler.sv
// Directed bench for mac_slot_scheduler; a behavioural half/float32 MAC with 4-cycle latency
// stands in for the external MAC instance.
module tb_mac_slot_scheduler;
  localparam int NCH     = 4;
  localparam int MAC_LAT = 4;
  localparam int LEN_W   = 8;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       start, busy, op_valid, op_ready, res_valid, res_ready;
  logic [NCH*LEN_W-1:0] len;
  logic [NCH*16-1:0]    op_a, op_b;
  logic [NCH*32-1:0]    res_data;
  logic                 mac_en;
  logic [15:0]          mac_a, mac_b;
  logic [31:0]          mac_c, mac_q;
  logic [2*NCH-1:0]     dbg_state;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [15:0]    feed_a [NCH][4];
  logic [15:0]    feed_b [NCH][4];
  int             feed_n   [NCH];
  int             feed_idx [NCH];
  logic [NCH-1:0] feed_gap, feed_phase;
  logic [15:0]    snap_a, snap_b;
  logic [31:0]    snap_c;

  always #5 clock = ~clock;

  mac_slot_scheduler #(.NCH(NCH), .MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .start(start), .len(len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_q(mac_q),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural MAC (normal numbers and zero only) ----------------
  function automatic real scale2(input real m, input int e);
    real r = m;
    for (int k = 0; k < e; k++) r = r * 2.0;
    for (int k = 0; k > e; k--) r = r / 2.0;
    return r;
  endfunction

  function automatic real half_to_real(input logic [15:0] h);
    real m;
    if (h[14:0] == 15'd0) return 0.0;
    m = scale2(1.0 + real'(h[9:0]) / 1024.0, int'(h[14:10]) - 15);
    return h[15] ? -m : m;
  endfunction

  function automatic real f32_to_real(input logic [31:0] f);
    real m;
    if (f[30:0] == 31'd0) return 0.0;
    m = scale2(1.0 + real'(f[22:0]) / 8388608.0, int'(f[30:23]) - 127);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real_to_f32(input real x);
    real v;
    int  e = 0;
    int  m;
    logic s;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    v = s ? -x : x;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m = int'((v - 1.0) * 8388608.0);
    return {s, 8'(e + 127), 23'(m)};
  endfunction

  logic [31:0] mac_pipe [MAC_LAT];
  always @(posedge clock) begin
    mac_pipe[0] <= real_to_f32(half_to_real(mac_a) * half_to_real(mac_b) + f32_to_real(mac_c));
    for (int k = 1; k < MAC_LAT; k++) mac_pipe[k] <= mac_pipe[k-1];
  end
  assign mac_q = mac_pipe[MAC_LAT-1];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    cycle++;
  endtask

  task automatic clear_feed();
    for (int i = 0; i < NCH; i++) begin
      feed_n[i]   = 0;
      feed_idx[i] = 0;
    end
    feed_gap   = '0;
    feed_phase = '0;
    op_valid   = '0;
    op_a       = '0;
    op_b       = '0;
  endtask

  // Drives one cycle of operands, snapshots the MAC inputs, and advances one clock.
  task automatic feed_cycle(output logic [NCH-1:0] hs);
    for (int i = 0; i < NCH; i++) begin
      if (feed_gap[i] && op_ready[i] && feed_phase[i]) begin
        op_valid[i]   = 1'b0;
        feed_phase[i] = 1'b0;
      end else begin
        op_valid[i] = (feed_idx[i] < feed_n[i]);
        if (feed_gap[i] && op_ready[i] && op_valid[i]) feed_phase[i] = 1'b1;
      end
      op_a[i*16 +: 16] = (op_valid[i] && feed_idx[i] < 4) ? feed_a[i][feed_idx[i]] : 16'h0;
      op_b[i*16 +: 16] = (op_valid[i] && feed_idx[i] < 4) ? feed_b[i][feed_idx[i]] : 16'h0;
      hs[i] = op_ready[i] && op_valid[i];
    end
    #1;
    snap_a = mac_a;
    snap_b = mac_b;
    snap_c = mac_c;
    @(posedge clock);
    #1;
    cycle++;
    for (int i = 0; i < NCH; i++) if (hs[i]) feed_idx[i]++;
  endtask

  task automatic load_ch(input int ch, input int n, input logic [15:0] a0, input logic [15:0] b0,
                         input logic [15:0] a1, input logic [15:0] b1,
                         input logic [15:0] a2, input logic [15:0] b2);
    feed_n[ch] = n; feed_idx[ch] = 0;
    feed_a[ch][0] = a0; feed_b[ch][0] = b0;
    feed_a[ch][1] = a1; feed_b[ch][1] = b1;
    feed_a[ch][2] = a2; feed_b[ch][2] = b2;
    feed_a[ch][3] = 16'h0; feed_b[ch][3] = 16'h0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL reset_busy: got %h want 0", busy); end
    total++; if (op_ready !== 4'h0) begin bad++; $display("FAIL reset_op_ready: got %h want 0", op_ready); end
    total++; if (res_valid !== 4'h0) begin bad++; $display("FAIL reset_res_valid: got %h want 0", res_valid); end
    total++; if (res_data !== '0) begin bad++; $display("FAIL reset_res_data: got %h want 0", res_data); end
    total++; if (mac_a !== 16'h0 || mac_b !== 16'h0) begin bad++; $display("FAIL reset_mac_ab: got %h/%h want 0/0", mac_a, mac_b); end
    total++; if (mac_c !== 32'h0) begin bad++; $display("FAIL reset_mac_c: got %h want 0", mac_c); end
    total++; if (mac_en !== 1'b1) begin bad++; $display("FAIL reset_mac_en: got %b want 1", mac_en); end
    total++; if (dbg_state !== 8'h0) begin bad++; $display("FAIL reset_state: got %h want 0", dbg_state); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [NCH-1:0] hs;
    int first_hs = -1, last_hs = -1, rv = -1, c;
    clear_feed();
    load_ch(0, 3, 16'h3C00, 16'h4000, 16'h4000, 16'h4200, 16'h4200, 16'h3C00);
    start = 4'b0001; len = '0; len[0 +: LEN_W] = 8'd3;
    feed_cycle(hs);
    start = '0;
    total++; if (busy !== 4'b0001) begin bad++; $display("FAIL single_busy: got %b want 0001", busy); end
    for (int k = 0; k < 60 && rv < 0; k++) begin
      c = cycle;
      feed_cycle(hs);
      if (hs[0]) begin if (first_hs < 0) first_hs = c; last_hs = c; end
      if (res_valid[0]) rv = cycle;
    end
    total++;
    if (rv < 0) begin bad++; $display("FAIL single_timeout: got no res_valid want res_valid[0]"); end
    else begin
      total++; if (last_hs - first_hs != 8) begin bad++; $display("FAIL single_issue_spacing: got %0d want 8", last_hs - first_hs); end
      total++; if (rv - first_hs != 13) begin bad++; $display("FAIL single_latency: got %0d want 13", rv - first_hs); end
      total++; if (res_data[31:0] !== 32'h41300000) begin bad++; $display("FAIL single_data: got %h want 41300000", res_data[31:0]); end
    end
    res_ready = 4'b0001;
    tick();
    res_ready = '0;
    total++; if (busy !== 4'h0 || res_valid !== 4'h0) begin bad++; $display("FAIL single_release: got busy=%b rv=%b want 0/0", busy, res_valid); end
  endtask

  task automatic test_four();
    logic [NCH-1:0] hs, rdy, prev;
    int n_iss [NCH];
    int first_hs = -1, last_hs = -1, issues = 0, c;
    logic done = 1'b0;
    clear_feed();
    for (int i = 0; i < NCH; i++) begin
      load_ch(i, 2, 16'h4000, 16'h3C00, 16'h4000, 16'h3C00, 16'h0, 16'h0);
      n_iss[i] = 0;
    end
    start = 4'hF; len = {8'd2, 8'd2, 8'd2, 8'd2};
    feed_cycle(hs);
    start = '0;
    prev = '0;
    for (int k = 0; k < 60 && !done; k++) begin
      c = cycle;
      rdy = op_ready;
      feed_cycle(hs);
      total++; if ($countones(rdy) > 1) begin bad++; $display("FAIL four_ready_onehot: got %b want at most one bit", rdy); end
      if (prev != '0 && rdy != '0) begin
        total++;
        if (rdy !== {prev[2:0], prev[3]}) begin bad++; $display("FAIL four_ready_rotation: got %b want %b", rdy, {prev[2:0], prev[3]}); end
      end
      prev = rdy;
      for (int j = 0; j < NCH; j++) begin
        if (hs[j]) begin
          if (first_hs < 0) first_hs = c;
          last_hs = c;
          issues++;
          total++;
          if (snap_a !== 16'h4000 || snap_b !== 16'h3C00) begin bad++; $display("FAIL four_mac_ab ch%0d: got %h/%h want 4000/3c00", j, snap_a, snap_b); end
          total++;
          if (snap_c !== ((n_iss[j] == 0) ? 32'h0 : 32'h40000000)) begin
            bad++; $display("FAIL four_mac_c ch%0d issue%0d: got %h want %h", j, n_iss[j], snap_c, (n_iss[j] == 0) ? 32'h0 : 32'h40000000);
          end
          n_iss[j]++;
        end
      end
      if (res_valid == 4'hF) done = 1'b1;
    end
    total++; if (!done) begin bad++; $display("FAIL four_timeout: got res_valid=%b want 1111", res_valid); end
    total++; if (issues != 8 || last_hs - first_hs != 7) begin bad++; $display("FAIL four_throughput: got %0d issues over %0d cycles want 8 over 7", issues, last_hs - first_hs); end
    for (int i = 0; i < NCH; i++) begin
      total++; if (res_data[i*32 +: 32] !== 32'h40800000) begin bad++; $display("FAIL four_data ch%0d: got %h want 40800000", i, res_data[i*32 +: 32]); end
    end
    res_ready = 4'hF;
    tick();
    res_ready = '0;
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL four_release: got %b want 0000", busy); end
  endtask

  task automatic test_len_zero();
    logic [NCH-1:0] hs;
    clear_feed();
    start = 4'b0100; len = '0;
    feed_cycle(hs);
    start = '0;
    total++; if (res_valid !== 4'b0100) begin bad++; $display("FAIL len0_valid: got %b want 0100", res_valid); end
    total++; if (res_data[95:64] !== 32'h0) begin bad++; $display("FAIL len0_data: got %h want 00000000", res_data[95:64]); end
    total++; if (snap_a !== 16'h0 || snap_c !== 32'h0 || mac_a !== 16'h0 || mac_c !== 32'h0) begin
      bad++; $display("FAIL len0_no_issue: got a=%h c=%h want 0/0", mac_a | snap_a, mac_c | snap_c);
    end
    res_ready = 4'b0100;
    tick();
    res_ready = '0;
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL len0_release: got %b want 0000", busy); end
  endtask

  task automatic test_gaps();
    logic [NCH-1:0] hs;
    int first_hs = -1, last_hs = -1, rv = -1, c;
    clear_feed();
    load_ch(1, 2, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0, 16'h0);
    feed_gap = 4'b0010;
    start = 4'b0010; len = '0; len[LEN_W +: LEN_W] = 8'd2;
    feed_cycle(hs);
    start = '0;
    for (int k = 0; k < 60 && rv < 0; k++) begin
      c = cycle;
      feed_cycle(hs);
      if (hs[1]) begin if (first_hs < 0) first_hs = c; last_hs = c; end
      if (res_valid[1]) rv = cycle;
    end
    total++;
    if (rv < 0) begin bad++; $display("FAIL gaps_timeout: got no res_valid want res_valid[1]"); end
    else begin
      total++; if (last_hs - first_hs != 8) begin bad++; $display("FAIL gaps_spacing: got %0d want 8", last_hs - first_hs); end
      total++; if (rv - first_hs != 13) begin bad++; $display("FAIL gaps_latency: got %0d want 13", rv - first_hs); end
      total++; if (res_data[63:32] !== 32'h41000000) begin bad++; $display("FAIL gaps_data: got %h want 41000000", res_data[63:32]); end
    end
    res_ready = 4'b0010;
    tick();
    res_ready = '0;
  endtask

  task automatic test_backpressure();
    logic [NCH-1:0] hs;
    int rv = -1;
    clear_feed();
    load_ch(3, 1, 16'h4000, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0);
    start = 4'b1000; len = '0; len[3*LEN_W +: LEN_W] = 8'd1;
    feed_cycle(hs);
    start = '0;
    for (int k = 0; k < 40 && rv < 0; k++) begin
      feed_cycle(hs);
      if (res_valid[3]) rv = cycle;
    end
    total++; if (rv < 0) begin bad++; $display("FAIL bp_timeout: got no res_valid want res_valid[3]"); end
    for (int k = 0; k < 10; k++) begin
      start = (k == 3) ? 4'b1000 : 4'b0000;
      len[3*LEN_W +: LEN_W] = 8'd5;
      feed_cycle(hs);
      total++;
      if (res_valid[3] !== 1'b1 || res_data[127:96] !== 32'h40000000 || busy[3] !== 1'b1 || op_ready[3] !== 1'b0) begin
        bad++; $display("FAIL bp_hold k=%0d: got rv=%b data=%h busy=%b rdy=%b want 1/40000000/1/0", k, res_valid[3], res_data[127:96], busy[3], op_ready[3]);
      end
    end
    start = '0;
    res_ready = 4'b1000;
    tick();
    res_ready = '0;
    total++; if (busy[3] !== 1'b0 || res_valid[3] !== 1'b0) begin bad++; $display("FAIL bp_release: got busy=%b rv=%b want 0/0", busy[3], res_valid[3]); end
    tick();
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL bp_start_ignored: got %b want 0000", busy); end
  endtask

  task automatic test_reset_mid_job();
    logic [NCH-1:0] hs;
    int hs0 = -1, rv = -1, c;
    clear_feed();
    for (int i = 0; i < NCH; i++) load_ch(i, 3, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    start = 4'hF; len = {8'd3, 8'd3, 8'd3, 8'd3};
    feed_cycle(hs);
    start = '0;
    for (int k = 0; k < 40 && feed_idx[0] < 3; k++) feed_cycle(hs);
    total++; if (dbg_state[1:0] !== 2'd2) begin bad++; $display("FAIL rst_pre_wait: got %0d want 2", dbg_state[1:0]); end
    clear_feed();
    reset = 1'b1;
    tick();
    total++; if (busy !== 4'h0 || op_ready !== 4'h0 || res_valid !== 4'h0) begin
      bad++; $display("FAIL rst_ctrl: got busy=%b rdy=%b rv=%b want 0/0/0", busy, op_ready, res_valid);
    end
    total++; if (res_data !== '0 || mac_a !== 16'h0 || mac_b !== 16'h0 || mac_c !== 32'h0 || mac_en !== 1'b1) begin
      bad++; $display("FAIL rst_data: got data=%h a=%h b=%h c=%h en=%b want 0/0/0/0/1", res_data, mac_a, mac_b, mac_c, mac_en);
    end
    reset = 1'b0;
    load_ch(0, 1, 16'h3C00, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0);
    start = 4'b0001; len = '0; len[0 +: LEN_W] = 8'd1;
    feed_cycle(hs);
    start = '0;
    for (int k = 0; k < 40 && rv < 0; k++) begin
      c = cycle;
      feed_cycle(hs);
      if (hs[0]) hs0 = c;
      if (res_valid != '0) rv = cycle;
    end
    total++;
    if (rv < 0) begin bad++; $display("FAIL rst_new_timeout: got no res_valid want res_valid[0]"); end
    else begin
      total++; if (res_valid !== 4'b0001) begin bad++; $display("FAIL rst_new_valid: got %b want 0001", res_valid); end
      total++; if (rv - hs0 != 5) begin bad++; $display("FAIL rst_new_latency: got %0d want 5", rv - hs0); end
      total++; if (res_data[31:0] !== 32'h3F800000) begin bad++; $display("FAIL rst_new_data: got %h want 3f800000", res_data[31:0]); end
    end
    res_ready = 4'b0001;
    tick();
    res_ready = '0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = '0;
    len       = '0;
    res_ready = '0;
    clear_feed();
    test_reset();
    test_single();
    test_four();
    test_len_zero();
    test_gaps();
    test_backpressure();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
